// File: rtl/rr_stream_arbiter.sv
// ---------------------------------------------------------------------------
// rr_stream_arbiter
//
// Shares one downstream valid/ready stream channel between N_REQ upstream
// requesters. Arbitration is round-robin and packet-aware. Once a requester
// wins, it keeps the channel from its first beat to its last beat. The output
// stage is a single register, so an accepted beat appears on the output one
// cycle later.
//
// Parameters:
//   N_REQ   number of requesters (>= 2)
//   DATA_W  payload width per beat
//   ID_W    width of out_id_o. It is derived from N_REQ and must not be
//           overridden.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   in_valid_i   per-requester beat valid
//   in_ready_o   per-requester beat accept (at most one bit high)
//   in_data_i    packed payloads; requester k at [k*DATA_W +: DATA_W]
//   in_last_i    per-requester end-of-packet flag
//   out_valid_o  output beat valid
//   out_ready_i  sink accept
//   out_data_o   output payload
//   out_last_o   output end-of-packet
//   out_id_o     index of the requester that produced the output beat
//   grant_cnt_o  (only with RR_ARB_GRANT_CNT_EN) one saturating 16-bit
//                count of completed packets per requester; requester k
//                at [k*16 +: 16]
//
// Optional feature macro: RR_ARB_GRANT_CNT_EN
// ---------------------------------------------------------------------------
module rr_stream_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 32,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef RR_ARB_GRANT_CNT_EN
  output logic [N_REQ*16-1:0]       grant_cnt_o,
`endif
  input  logic [N_REQ-1:0]          in_valid_i,
  output logic [N_REQ-1:0]          in_ready_o,
  input  logic [N_REQ*DATA_W-1:0]   in_data_i,
  input  logic [N_REQ-1:0]          in_last_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_last_o,
  output logic [ID_W-1:0]           out_id_o
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e            state_q,     state_d;
  logic [ID_W-1:0]   lock_id_q,   lock_id_d;
  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic [ID_W-1:0]   out_id_q,    out_id_d;

  logic              slot_free;
  logic [ID_W-1:0]   grant;
  logic              grant_valid;
  logic              xfer;
  logic [DATA_W-1:0] beat_data;
  logic              beat_last;

  // The output register can take a new beat when it is empty or being popped.
  assign slot_free = ~out_valid_q | out_ready_i;

  // Grant selection. While LOCKED, the owner keeps the grant even if it drops
  // valid. While IDLE, the search starts at the requester after the last
  // packet winner and wraps around.
  // NOTE: assign every output of a combinational block first, before any
  // branch. Otherwise an uncovered path infers a latch.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (state_q == LOCKED) begin
      grant       = lock_id_q;
      grant_valid = 1'b1;
    end else begin
      for (int i = 1; i <= N_REQ; i++) begin
        if (!grant_valid && in_valid_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
          grant       = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Ready is gated by rst. This keeps every output at its reset value for as
  // long as reset is held, even though ready is combinational.
  always_comb begin
    in_ready_o = '0;
    if (!rst && slot_free && grant_valid) begin
      in_ready_o[grant] = 1'b1;
    end
  end

  assign beat_data = in_data_i[int'(grant)*DATA_W +: DATA_W];
  assign beat_last = in_last_i[grant];
  assign xfer      = grant_valid & slot_free & in_valid_i[grant];

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data;
      out_last_d  = beat_last;
      out_id_d    = grant;
      if (beat_last) begin
        // The packet is complete, so release the channel and move the
        // round-robin pointer. A single-beat packet never locks.
        state_d  = IDLE;
        rr_ptr_d = grant;
      end else begin
        state_d   = LOCKED;
        lock_id_d = grant;
      end
    end else if (out_ready_i) begin
      // Pop with no replacement: clear the whole output beat.
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
      out_id_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so that every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_id_q   <= '0;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_id_o    = out_id_q;

`ifdef RR_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt_q [N_REQ];

  // NOTE: this counter array is software-visible, so it is reset. Storage
  // that is only read after being written would not need a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        grant_cnt_q[k] <= '0;
      end
    end else if (xfer && beat_last && grant_cnt_q[grant] != 16'hFFFF) begin
      grant_cnt_q[grant] <= grant_cnt_q[grant] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      grant_cnt_o[k*16 +: 16] = grant_cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_stream_arbiter
//
// Self-checking bench for rr_stream_arbiter with N_REQ=4 and DATA_W=8.
// The directed steps are followed by a randomized phase. A packet-level
// reference model predicts the ready vector and the registered output beat
// on every cycle. The model tracks the current packet owner (-1 when no
// packet is open) and the last packet winner.
// ---------------------------------------------------------------------------
module tb_rr_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid_i;
  logic [N-1:0]  in_ready_o;
  logic [N*DW-1:0] in_data_i;
  logic [N-1:0]  in_last_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic [1:0]    out_id_o;
`ifdef RR_ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt_o;
`endif

  rr_stream_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef RR_ARB_GRANT_CNT_EN
    .grant_cnt_o (grant_cnt_o),
`endif
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_id_o    (out_id_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_last;
  int       m_id;
  int       m_owner;   // requester holding an open packet, -1 if none
  int       m_winner;  // requester that completed the most recent packet

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_last   = 1'b0;
    m_id     = 0;
    m_owner  = -1;
    m_winner = N - 1;
  endtask

  // Runs one clock cycle. On entry the time is just after a rising edge and
  // the inputs are already set. At the falling edge, outputs and ready are
  // compared with the model and the model is advanced. The task returns 1 time
  // unit after the next rising edge.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    int g;
    bit slot;
    @(negedge clk);
    check("out_valid", 32'(out_valid_o), 32'(m_valid));
    check("out_data",  32'(out_data_o),  32'(m_data));
    check("out_last",  32'(out_last_o),  32'(m_last));
    check("out_id",    32'(out_id_o),    32'(m_id));
    slot    = !m_valid || out_ready_i;
    exp_rdy = '0;
    g       = -1;
    if (slot) begin
      if (m_owner >= 0) g = m_owner;
      else begin
        for (int j = 1; j <= N; j++) begin
          int c;
          c = (m_winner + j) % N;
          if (g < 0 && in_valid_i[c]) g = c;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("in_ready", 32'(in_ready_o), 32'(exp_rdy));
    if (g >= 0 && in_valid_i[g]) begin
      m_valid = 1'b1;
      m_data  = in_data_i[g*DW +: DW];
      m_last  = in_last_i[g];
      m_id    = g;
      if (in_last_i[g]) begin
        m_owner  = -1;
        m_winner = g;
      end else begin
        m_owner = g;
      end
    end else if (out_ready_i) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_last  = 1'b0;
      m_id    = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset immediately, without waiting for a clock edge, and checks
  // that every output is at its reset value while reset is held.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_data",  32'(out_data_o),  32'd0);
    check("rst_out_last",  32'(out_last_o),  32'd0);
    check("rst_out_id",    32'(out_id_o),    32'd0);
    check("rst_in_ready",  32'(in_ready_o),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid_i  = 4'b1111;  // ready must stay low during reset regardless
    in_data_i   = '0;
    in_last_i   = '0;
    out_ready_i = 1'b1;
    model_reset();

    // Reset state
    do_reset();

    // Single-beat packet from requester 0
    in_valid_i = 4'b0001; in_data_i = 32'h0000_00A5; in_last_i = 4'b0001;
    #1 check("a5_ready", 32'(in_ready_o), 32'h1);
    cycle();
    check("a5_valid", 32'(out_valid_o), 32'd1);
    check("a5_data",  32'(out_data_o),  32'hA5);
    check("a5_id",    32'(out_id_o),    32'd0);
    check("a5_last",  32'(out_last_o),  32'd1);
    in_valid_i = 4'b0000;
    cycle();
    check("a5_pop_valid", 32'(out_valid_o), 32'd0);
    check("a5_pop_data",  32'(out_data_o),  32'd0);

    // Round robin, all requesters valid with single-beat packets
    do_reset();
    in_valid_i = 4'b1111; in_data_i = 32'h4332_2110; in_last_i = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_valid", 32'(out_valid_o), 32'd1);
      check("rr_id",    32'(out_id_o),    32'(i % 4));
    end

    // Move the pointer to requester 0, then run a 3-beat packet from 1
    // while requester 2 is valid throughout
    in_valid_i = 4'b0001; in_data_i = 32'h0000_0001; in_last_i = 4'b0001;
    cycle();
    in_valid_i = 4'b0110; in_data_i = 32'h0022_1100; in_last_i = 4'b0100;
    #1 check("pkt_ready", 32'(in_ready_o), 32'h2);
    cycle();
    check("pkt_b0_id", 32'(out_id_o), 32'd1);
    check("pkt_b0_data", 32'(out_data_o), 32'h11);
    in_data_i = 32'h0022_1200;
    cycle();
    check("pkt_b1_id", 32'(out_id_o), 32'd1);
    check("pkt_b1_data", 32'(out_data_o), 32'h12);
    in_data_i = 32'h0022_1300; in_last_i = 4'b0110;
    cycle();
    check("pkt_b2_id", 32'(out_id_o), 32'd1);
    check("pkt_b2_data", 32'(out_data_o), 32'h13);
    check("pkt_b2_last", 32'(out_last_o), 32'd1);
    in_valid_i = 4'b0100;
    cycle();
    check("pkt_r2_id", 32'(out_id_o), 32'd2);
    check("pkt_r2_data", 32'(out_data_o), 32'h22);
    in_valid_i = 4'b0000;
    cycle();

    // Output stall
    in_valid_i = 4'b0001; in_data_i = 32'h0000_005A; in_last_i = 4'b0001;
    cycle();
    out_ready_i = 1'b0;
    in_valid_i = 4'b1000; in_data_i = 32'h7700_0000; in_last_i = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_data",  32'(out_data_o), 32'h5A);
      check("stall_ready", 32'(in_ready_o), 32'h0);
    end
    out_ready_i = 1'b1;
    cycle();
    check("stall_r3_data", 32'(out_data_o), 32'h77);
    check("stall_r3_id",   32'(out_id_o),   32'd3);
    in_valid_i = 4'b0000;
    cycle();

    // Reset while LOCKED on requester 2
    in_valid_i = 4'b0100; in_data_i = 32'h0099_0000; in_last_i = 4'b0000;
    cycle();
    in_valid_i = 4'b0101;
    #1 check("lock_ready", 32'(in_ready_o), 32'h4);
    do_reset();
    in_valid_i = 4'b0101; in_last_i = 4'b0101; in_data_i = 32'h0088_0044;
    #1 check("post_rst_ready", 32'(in_ready_o), 32'h1);
    cycle();
    check("post_rst_id", 32'(out_id_o), 32'd0);
    in_valid_i = 4'b0000;
    cycle();

    // Randomized traffic checked against the model
    for (int i = 0; i < 1500; i++) begin
      in_valid_i  = 4'($urandom);
      in_data_i   = $urandom;
      for (int k = 0; k < N; k++) in_last_i[k] = ($urandom_range(0, 2) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end

`ifdef RR_ARB_GRANT_CNT_EN
    // Packet counters
    in_valid_i = 4'b0000; out_ready_i = 1'b1;
    do_reset();
    in_valid_i = 4'b0100; in_last_i = 4'b0100; in_data_i = 32'h0055_0000;
    for (int i = 0; i < 5; i++) cycle();
    in_valid_i = 4'b0000;
    cycle();
    check("cnt0", 32'(grant_cnt_o[0*16 +: 16]), 32'd0);
    check("cnt1", 32'(grant_cnt_o[1*16 +: 16]), 32'd0);
    check("cnt2", 32'(grant_cnt_o[2*16 +: 16]), 32'd5);
    check("cnt3", 32'(grant_cnt_o[3*16 +: 16]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Shares one downstream valid/ready stream channel between N_REQ upstream requesters.
- Arbitration is round-robin and packet-aware. A grant is held from the first beat until the beat with last asserted.
- The output is registered, so there is 1 cycle of latency from an accepted input beat to its appearance on the output.
- Sits in front of a skid buffer or interconnect port wherever several masters feed a single stream sink.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- DATA_W, 32, payload width per beat.
- ID_W, $clog2(N_REQ), width of the source-index field on the output (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid_i  in  N_REQ  per-requester beat valid.
- in_ready_o  out  N_REQ  per-requester beat accept; at most one bit high per cycle.
- in_data_i  in  N_REQ*DATA_W  packed payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- in_last_i  in  N_REQ  per-requester end-of-packet flag.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  sink accept.
- out_data_o  out  DATA_W  output payload.
- out_last_o  out  1  output end-of-packet.
- out_id_o  out  ID_W  index of the requester that produced the output beat.

Behaviour:
- Reset values: out_valid_o=0, out_data_o=0, out_last_o=0, out_id_o=0, in_ready_o=0, state=IDLE, rr_ptr=N_REQ-1 (requester 0 has highest priority after reset).
- Slot-free condition: slot_free = ~out_valid_o | out_ready_i.
- State machine has two states:
  - IDLE: grant is computed combinationally. It goes to the first k with in_valid_i[k]=1, searching from rr_ptr+1 modulo N_REQ upward with wrap.
  - LOCKED: grant is fixed to lock_id. No re-arbitration is performed.
- Ready rule: in_ready_o[k] = slot_free & (k == grant) & grant_valid. Ready never depends on in_valid_i of any other requester once in LOCKED.
- An input beat transfers on in_valid_i[k] & in_ready_o[k]. On the next edge:
  - out_valid_o=1; out_data_o/out_last_o take the beat's values; out_id_o=k.
  - If in_last_i[k]=1: state becomes IDLE and rr_ptr=k.
  - Else: state becomes LOCKED and lock_id=k.
- A single-beat packet (last=1 on its first beat) never enters LOCKED.
- Output pop with no new transfer (out_ready_i=1, no input transfer): out_valid_o becomes 0 and out_data_o, out_last_o, out_id_o become 0.
- Output stall (out_valid_o=1, out_ready_i=0): all output signals hold and all in_ready_o are 0.
- Throughput is 1 beat per cycle when the sink is always ready.
- LOCKED with the owner deasserting in_valid_i: grant is held and the channel idles. Other requesters are not served until the owner sends its last beat.
- rr_ptr updates only on packet completion, not on every beat.
- Reset mid-packet: asynchronous return to the reset values; any partial packet is dropped with no recovery.
- in_data_i and in_last_i of non-granted requesters are ignored.

Optional Feature:
- Macro: RR_ARB_GRANT_CNT_EN.
- Defined: adds output grant_cnt_o (N_REQ*16 bits).
  - One 16-bit counter per requester, incremented on each completed packet (last-beat transfer) from that requester.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan (N_REQ=4, DATA_W=8):
- Reset, then in_valid_i=4'b0001, data0=8'hA5, last=1, out_ready_i=1.
  - in_ready_o=4'b0001.
  - Next cycle: out_valid_o=1, out_data_o=8'hA5, out_id_o=0, out_last_o=1.
  - Following cycle: out_valid_o=0, out_data_o=0.
- All four requesters continuously valid with single-beat packets, sink always ready.
  - out_id_o sequence is 0,1,2,3,0,1.
  - One beat per cycle, no bubbles.
- Requester 1 sends a 3-beat packet (8'h11, 8'h12, 8'h13 with last) while requester 2 is valid throughout.
  - out_id_o=1 for all three beats.
  - Requester 2's first beat appears only after 8'h13.
- Stall: out_valid_o=1 with 8'h5A, hold out_ready_i=0 for 3 cycles while requester 3 is valid.
  - out_data_o holds 8'h5A and in_ready_o=0 for those 3 cycles.
  - After out_ready_i rises, requester 3's beat appears one cycle later.
- Assert rst while LOCKED on requester 2, mid-packet.
  - All outputs immediately return to their reset values (out_valid_o=0, out_data_o=0, out_last_o=0, out_id_o=0, in_ready_o=0).
  - After release, requesters 0 and 2 both valid: requester 0 is granted first.
- RR_ARB_GRANT_CNT_EN defined, 5 single-beat packets from requester 2.
  - grant_cnt_o[2*16 +: 16]=5; all other counters are 0.
